// File: rtl/pipe_stage_buffer.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry skid, stall and flush.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall_cycles / bubble_cycles counters.
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
`endif
);

  logic             w_accept;
  logic             w_send;
  logic             w_clear;
  logic             w_rdy;
  logic             w_valid;
  logic [WIDTH-1:0] w_head;
  logic [1:0]       w_occ;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_buffer: CNT_W must be at least 1");
  end

  assign w_clear   = rst | flush;
  assign in_ready  = w_rdy & ~stall & ~rst;
  assign out_valid = w_valid & ~stall;
  assign out_data  = out_valid ? w_head : '0;
  assign occupancy = w_occ;
  assign w_accept  = in_valid & in_ready;
  assign w_send    = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] w_head_next;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_next;
    logic             r_rdy;

    always_comb begin
      w_state_next = r_state;
      w_head_next  = r_head;
      w_skid_next  = r_skid;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_ONE;
            w_head_next  = in_data;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_send) begin
            w_state_next = ST_TWO;
            w_skid_next  = in_data;
          end else if (w_send && !w_accept) begin
            w_state_next = ST_EMPTY;
            w_head_next  = '0;
          end else if (w_send && w_accept) begin
            w_head_next  = in_data;
          end
        end
        ST_TWO: begin
          if (w_send) begin
            w_state_next = ST_ONE;
            w_head_next  = r_skid;
            w_skid_next  = '0;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
          w_head_next  = '0;
          w_skid_next  = '0;
        end
      endcase
    end

    // Ready is registered from the next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
      if (w_clear) begin
        r_state <= ST_EMPTY;
        r_head  <= '0;
        r_skid  <= '0;
        r_rdy   <= 1'b1;
      end else begin
        r_state <= w_state_next;
        r_head  <= w_head_next;
        r_skid  <= w_skid_next;
        r_rdy   <= (w_state_next != ST_TWO);
      end
    end

    assign w_rdy   = r_rdy;
    assign w_valid = (r_state != ST_EMPTY);
    assign w_head  = r_head;
    assign w_occ   = (r_state == ST_TWO) ? 2'd2 : (r_state == ST_ONE) ? 2'd1 : 2'd0;
  end else begin : g_single
    logic             r_full;
    logic [WIDTH-1:0] r_head;

    always_ff @(posedge clk) begin
      if (w_clear) begin
        r_full <= 1'b0;
        r_head <= '0;
      end else if (w_accept) begin
        r_full <= 1'b1;
        r_head <= in_data;
      end else if (w_send) begin
        r_full <= 1'b0;
        r_head <= '0;
      end
    end

    assign w_rdy   = ~r_full | out_ready;
    assign w_valid = r_full;
    assign w_head  = r_head;
    assign w_occ   = {1'b0, r_full};
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && (w_occ != 2'd0) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!out_valid && out_ready && !stall && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles  = r_stall_cnt;
  assign bubble_cycles = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: SKID=1 and SKID=0 instances share stimulus,
// each compared against a queue-based model of the stage.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, stall, flush;
  logic [31:0] in_data;

  logic        rdy1, vld1, rdy0, vld0;
  logic [31:0] dat1, dat0;
  logic [1:0]  occ1, occ0;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] sc1, bc1, sc0, bc0;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int sc_m1 = 0, bc_m1 = 0, sc_m0 = 0, bc_m0 = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(32), .SKID(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .stall(stall), .flush(flush),
    .occupancy(occ1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(sc1), .bubble_cycles(bc1)
`endif
  );

  pipe_stage_buffer #(.WIDTH(32), .SKID(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .stall(stall), .flush(flush),
    .occupancy(occ0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(sc0), .bubble_cycles(bc0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic o,
                      input logic s, input logic f, input logic r);
    logic e_v1, e_r1, e_v0, e_r0;
    int   n1, n0;
    in_valid = v; in_data = d; out_ready = o; stall = s; flush = f; rst = r;
    #1;
    n1   = q1.size();
    n0   = q0.size();
    e_v1 = (n1 > 0) && !s;
    e_r1 = !s && !r && (n1 < 2);
    e_v0 = (n0 > 0) && !s;
    e_r0 = !s && !r && ((n0 == 0) || o);
    chk("skid_in_ready",  {31'b0, rdy1}, {31'b0, e_r1});
    chk("skid_out_valid", {31'b0, vld1}, {31'b0, e_v1});
    chk("skid_out_data",  dat1, e_v1 ? q1[0] : 32'h0);
    chk("skid_occupancy", {30'b0, occ1}, 32'(n1));
    chk("single_in_ready",  {31'b0, rdy0}, {31'b0, e_r0});
    chk("single_out_valid", {31'b0, vld0}, {31'b0, e_v0});
    chk("single_out_data",  dat0, e_v0 ? q0[0] : 32'h0);
    chk("single_occupancy", {30'b0, occ0}, 32'(n0));
`ifdef PIPE_STAGE_PERF_EN
    chk("skid_stall_cycles",    sc1, 32'(sc_m1));
    chk("skid_bubble_cycles",   bc1, 32'(bc_m1));
    chk("single_stall_cycles",  sc0, 32'(sc_m0));
    chk("single_bubble_cycles", bc0, 32'(bc_m0));
`endif
    $display("step v=%0b d=%h ordy=%0b stall=%0b flush=%0b rst=%0b | skid occ=%0d out=%h | single occ=%0d out=%h",
             v, d, o, s, f, r, occ1, dat1, occ0, dat0);
    @(posedge clk);
    if (r) begin
      sc_m1 = 0; bc_m1 = 0; sc_m0 = 0; bc_m0 = 0;
    end else begin
      if (s && n1 != 0) sc_m1++;
      if (s && n0 != 0) sc_m0++;
      if (!e_v1 && o && !s) bc_m1++;
      if (!e_v0 && o && !s) bc_m0++;
    end
    if (r || f) begin
      q1.delete();
      q0.delete();
    end else begin
      if (e_v1 && o) void'(q1.pop_front());
      if (v && e_r1) q1.push_back(d);
      if (e_v0 && o) void'(q0.pop_front());
      if (v && e_r0) q0.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Checked reset cycle: in_ready must be low while rst is held.
    step(0, 32'h0, 0, 0, 0, 1);

    // Streaming 0x1..0x10 at full rate.
    for (int i = 1; i <= 16; i++) step(1, 32'(i), 1, 0, 0, 0);
    repeat (2) step(0, 32'h0, 1, 0, 0, 0);

    // Backpressure then drain.
    step(1, 32'hA, 0, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0, 0);
    repeat (3) step(0, 32'h0, 1, 0, 0, 0);

    // Stall holds state and blocks both handshakes.
    step(1, 32'h55, 0, 0, 0, 0);
    repeat (3) step(1, 32'h66, 1, 1, 0, 0);
    repeat (2) step(0, 32'h0, 1, 0, 0, 0);

    // Flush beats stall and a pending input.
    step(1, 32'h1, 0, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0, 0);
    step(1, 32'h3, 0, 1, 1, 0);
    repeat (2) step(0, 32'h0, 1, 0, 0, 0);

    // Full single-entry stage refills in the same cycle it drains.
    step(1, 32'h7, 0, 0, 0, 0);
    step(1, 32'h8, 1, 0, 0, 0);
    repeat (3) step(0, 32'h0, 1, 0, 0, 0);

    // Counter scenario: stalls at occupancy 1, empty cycles, flush, then reset.
    step(1, 32'h9, 0, 0, 0, 0);
    repeat (5) step(0, 32'h0, 0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0, 0);
    repeat (3) step(0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
